spmv_sram_arbiter: RTL and testbench

//  Shares one 256-bit x 32-entry SRAM port between two requesters: R0 = SpMV ops engine,
//  R1 = host/poll controller (status poll, result readout, DONE flag write).

---
 rtl/spmv_pkg.sv | 19 +
 rtl/spmv_rd_tag_pipe.sv | 31 +++
 rtl/spmv_sram_arbiter.sv | 123 ++++++++++++
 tb/tb_spmv_sram_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spmv_pkg.sv
// Shared definitions for the SpMV SRAM arbiter: owner encodings, default widths
// and the read-return tag carried down the latency pipe.
package spmv_pkg;

  localparam int DW_DEF = 256;
  localparam int AW_DEF = 5;

  typedef enum logic [1:0] {
    OWNER_IDLE = 2'b00,
    OWNER_R0   = 2'b01,
    OWNER_R1   = 2'b10
  } owner_e;

  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;

endpackage

// File: rtl/spmv_rd_tag_pipe.sv
// RD_LAT-deep shift register of {valid, id} tags; the tail lines up with the
// SRAM read data so each return is routed to the requester that issued it.
module spmv_rd_tag_pipe
  import spmv_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic push_valid,
  input  logic push_id,
  output logic tail_valid,
  output logic tail_id
);

  rd_tag_t stage [RD_LAT];

  // NOTE: every stage is reset, not just the head, so in-flight reads are dropped on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) stage[i] <= '0;
    end else begin
      stage[0] <= '{valid: push_valid, id: push_id};
      for (int i = 1; i < RD_LAT; i++) stage[i] <= stage[i-1];
    end
  end

  assign tail_valid = stage[RD_LAT-1].valid;
  assign tail_id    = stage[RD_LAT-1].id;

endmodule

// File: rtl/spmv_sram_arbiter.sv
// Round-robin arbiter with burst lock sharing one SRAM port between the SpMV ops
// engine (R0) and the host/poll controller (R1), with tag-routed read returns.
module spmv_sram_arbiter
  import spmv_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int AW        = AW_DEF,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_req0,
  input  logic          i_req1,
  input  logic          i_last0,
  input  logic          i_last1,
  input  logic          i_wr0,
  input  logic          i_wr1,
  input  logic [AW-1:0] i_addr0,
  input  logic [AW-1:0] i_addr1,
  input  logic [DW-1:0] i_wdata0,
  input  logic [DW-1:0] i_wdata1,
  output logic          o_gnt0,
  output logic          o_gnt1,
  output logic          o_rvalid0,
  output logic          o_rvalid1,
  output logic [DW-1:0] o_rdata,
  output logic [AW-1:0] o_address,
  output logic          o_wr_en,
  output logic [DW-1:0] o_write_data,
  input  logic [DW-1:0] i_read_data,
  output logic [1:0]    o_owner
);

  localparam int            CW      = $clog2(MAX_BURST);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST - 1);

  owner_e        state;
  logic          last_owner;
  logic [CW-1:0] burst_cnt;
  logic          at_max;
  logic          release0;
  logic          release1;
  logic          tail_valid;
  logic          tail_id;

  assign o_gnt0 = (state == OWNER_R0) && i_req0;
  assign o_gnt1 = (state == OWNER_R1) && i_req1;
  assign at_max = (burst_cnt == CNT_MAX);

  // Only evaluated while the side owns the port, where grant == req.
  assign release0 = !i_req0 || i_last0 || (at_max && i_req1);
  assign release1 = !i_req1 || i_last1 || (at_max && i_req0);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= OWNER_IDLE;
      last_owner <= 1'b1;
      burst_cnt  <= '0;
    end else begin
      case (state)
        OWNER_IDLE: begin
          if (i_req0 && i_req1) state <= last_owner ? OWNER_R0 : OWNER_R1;
          else if (i_req0)      state <= OWNER_R0;
          else if (i_req1)      state <= OWNER_R1;
        end
        OWNER_R0: begin
          if (release0) begin
            state      <= i_req1 ? OWNER_R1 : OWNER_IDLE;
            last_owner <= 1'b0;
            burst_cnt  <= '0;
          end else if (!at_max) begin
            burst_cnt <= burst_cnt + 1'b1;
          end
        end
        OWNER_R1: begin
          if (release1) begin
            state      <= i_req0 ? OWNER_R0 : OWNER_IDLE;
            last_owner <= 1'b1;
            burst_cnt  <= '0;
          end else if (!at_max) begin
            burst_cnt <= burst_cnt + 1'b1;
          end
        end
        default: state <= OWNER_IDLE;
      endcase
    end
  end

  // NOTE: outputs get defaults before the mux so no path leaves them unassigned (no latch).
  always_comb begin
    o_address    = '0;
    o_wr_en      = 1'b0;
    o_write_data = '0;
    if (o_gnt0) begin
      o_address    = i_addr0;
      o_wr_en      = i_wr0;
      o_write_data = i_wdata0;
    end else if (o_gnt1) begin
      o_address    = i_addr1;
      o_wr_en      = i_wr1;
      o_write_data = i_wdata1;
    end
  end

  spmv_rd_tag_pipe #(
    .RD_LAT(RD_LAT)
  ) u_rd_tag_pipe (
    .clk       (i_clk),
    .rst       (i_rst),
    .push_valid((o_gnt0 && !i_wr0) || (o_gnt1 && !i_wr1)),
    .push_id   (o_gnt1),
    .tail_valid(tail_valid),
    .tail_id   (tail_id)
  );

  assign o_rvalid0 = tail_valid && !tail_id;
  assign o_rvalid1 = tail_valid && tail_id;
  assign o_rdata   = tail_valid ? i_read_data : '0;
  assign o_owner   = state;

endmodule

// File: tb/tb_spmv_sram_arbiter.sv
// Self-checking bench for spmv_sram_arbiter: directed scenarios plus random traffic,
// compared cycle by cycle against a transaction-level arbitration model.
module tb_spmv_sram_arbiter;

  localparam int DW        = 256;
  localparam int AW        = 5;
  localparam int RD_LAT    = 2;
  localparam int MAX_BURST = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, last0, last1, wr0, wr1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1, wr_en;
  logic [DW-1:0] rdata, write_data, read_data;
  logic [AW-1:0] address;
  logic [1:0]    owner;

  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;
  logic [DW-1:0] mem [32];
  logic [DW-1:0] rd_q0, rd_q1;

  always #5 clk = ~clk;

  spmv_sram_arbiter #(
    .DW(DW), .AW(AW), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0(req0), .i_req1(req1), .i_last0(last0), .i_last1(last1),
    .i_wr0(wr0), .i_wr1(wr1), .i_addr0(addr0), .i_addr1(addr1),
    .i_wdata0(wdata0), .i_wdata1(wdata1),
    .o_gnt0(gnt0), .o_gnt1(gnt1), .o_rvalid0(rvalid0), .o_rvalid1(rvalid1),
    .o_rdata(rdata), .o_address(address), .o_wr_en(wr_en),
    .o_write_data(write_data), .i_read_data(read_data), .o_owner(owner)
  );

  // SRAM with a two-stage read pipeline and a bench-side preload port.
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (wr_en) mem[address] <= write_data;
    rd_q0 <= mem[address];
    rd_q1 <= rd_q0;
  end
  assign read_data = rd_q1;

  // Reference model state: who owns the port, accesses in this burst, expected returns.
  typedef struct {
    int          due;
    bit          id;
    logic [DW-1:0] data;
  } rd_exp_t;

  int            m_owner;
  bit            m_last;
  int            m_nacc;
  logic [DW-1:0] shadow [32];
  rd_exp_t       rq [$];
  logic          m_gnt0, m_gnt1;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  logic          obs_gnt0, obs_gnt1, obs_rv0, obs_rv1, obs_wr_en;
  logic [AW-1:0] obs_addr;
  logic [DW-1:0] obs_rdata;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand256();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic idle_inputs();
    req0 = 0; req1 = 0; last0 = 0; last1 = 0; wr0 = 0; wr1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    pre_we = 0; pre_addr = '0; pre_data = '0;
  endtask

  // One clock: predict, sample at negedge, compare, then advance the model at posedge.
  task automatic tick();
    logic          e_we, e_rv0, e_rv1;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd, e_rd;
    logic [1:0]    e_own;
    bit            a, w;
    logic [AW-1:0] ad;
    int            x;
    bit            rq_x, oth, lst;

    m_gnt0 = (m_owner == 0) && req0;
    m_gnt1 = (m_owner == 1) && req1;
    e_we = 0; e_addr = '0; e_wd = '0;
    if (m_gnt0) begin e_we = wr0; e_addr = addr0; e_wd = wdata0; end
    else if (m_gnt1) begin e_we = wr1; e_addr = addr1; e_wd = wdata1; end
    e_own = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
    e_rv0 = 0; e_rv1 = 0; e_rd = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      e_rv0 = !rq[0].id; e_rv1 = rq[0].id; e_rd = rq[0].data;
    end

    @(negedge clk);
    obs_gnt0 = gnt0; obs_gnt1 = gnt1; obs_rv0 = rvalid0; obs_rv1 = rvalid1;
    obs_wr_en = wr_en; obs_addr = address; obs_rdata = rdata;
    if (chk_en) begin
      check("gnt0", gnt0, m_gnt0);
      check("gnt1", gnt1, m_gnt1);
      check("rvalid0", rvalid0, e_rv0);
      check("rvalid1", rvalid1, e_rv1);
      check("wr_en", wr_en, e_we);
      check("address", address, e_addr);
      check("write_data", write_data, e_wd);
      check("owner", owner, e_own);
      if (e_rv0 || e_rv1) check("rdata", rdata, e_rd);
    end

    @(posedge clk);
    if (rq.size() > 0 && rq[0].due == cyc) void'(rq.pop_front());
    if (pre_we) shadow[pre_addr] = pre_data;
    if (m_gnt0 || m_gnt1) begin
      a  = m_gnt1;
      w  = a ? wr1 : wr0;
      ad = a ? addr1 : addr0;
      if (w) shadow[ad] = a ? wdata1 : wdata0;
      else rq.push_back('{due: cyc + RD_LAT, id: a, data: shadow[ad]});
    end
    if (rst) begin
      m_owner = -1; m_last = 1; m_nacc = 0; rq.delete();
    end else if (m_owner < 0) begin
      if (req0 && req1) m_owner = m_last ? 0 : 1;
      else if (req0) m_owner = 0;
      else if (req1) m_owner = 1;
    end else begin
      x    = m_owner;
      rq_x = x ? req1 : req0;
      oth  = x ? req0 : req1;
      lst  = x ? last1 : last0;
      if (rq_x) m_nacc++;
      if (!rq_x || lst || (m_nacc >= MAX_BURST && oth)) begin
        m_last  = bit'(x);
        m_nacc  = 0;
        m_owner = oth ? 1 - x : -1;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  initial begin
    int first, n0, cnt0, wr_cnt;
    bit saw1;
    logic [DW-1:0] exp3, exp4;
    int rem [2];

    m_owner = -1; m_last = 1; m_nacc = 0;
    idle_inputs();
    rst = 1;

    // Reset held while preloading the SRAM; outputs must stay quiet.
    for (int i = 0; i < 32; i++) begin
      pre_we = 1; pre_addr = AW'(i); pre_data = rand256();
      tick();
      chk_en = 1'b1;
    end
    pre_we = 0;

    // Scenario 1: reset with req0 high, then first grant after release.
    req0 = 1; last0 = 1;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("t1_rst_gnt0", obs_gnt0, 1'b0);
      check("t1_rst_wr_en", obs_wr_en, 1'b0);
      check("t1_rst_addr", obs_addr, '0);
      check("t1_rst_rdata", obs_rdata, '0);
    end
    rst = 0;
    first = -1;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (obs_gnt0 && first < 0) first = k;
      if (m_gnt0) req0 = 0;
    end
    check("t1_first_gnt_cycle", first, 1);

    // Scenario 2: tie goes to R0, 3-access burst, zero-bubble hand-over to R1.
    do_reset();
    req0 = 1; req1 = 1; last1 = 1;
    n0 = 0; first = -1;
    for (int k = 0; k < 10 && n0 < 3; k++) begin
      last0 = (n0 == 2);
      tick();
      if (obs_gnt0 && first < 0) first = k;
      if (m_gnt0) n0++;
    end
    check("t2_tie_r0_cycle", first, 1);
    req0 = 0;
    tick();
    check("t2_gnt1_no_bubble", obs_gnt1, 1'b1);
    req1 = 0;
    tick();

    // Scenario 3: forced release after MAX_BURST accesses under contention.
    req0 = 1; last0 = 0;
    cnt0 = 0; saw1 = 0;
    for (int k = 0; k < 40 && !saw1; k++) begin
      if (k == 5) begin req1 = 1; last1 = 0; end
      tick();
      if (obs_gnt0) cnt0++;
      if (obs_gnt1) saw1 = 1;
    end
    check("t3_r0_grants", cnt0, MAX_BURST);
    check("t3_handover_r1", saw1, 1'b1);
    req0 = 0; req1 = 0;
    tick();

    // Scenario 4: long uncontended burst is never cut.
    req0 = 1; last0 = 0;
    tick();
    cnt0 = 0;
    for (int i = 0; i < 40; i++) begin
      last0 = (i == 39);
      addr0 = AW'($urandom);
      tick();
      if (obs_gnt0) cnt0++;
    end
    check("t4_consecutive_gnt0", cnt0, 40);
    req0 = 0; last0 = 0;
    tick();

    // Scenario 5: read on the hand-over cycle returns to R0, next read to R1.
    exp3 = shadow[3]; exp4 = shadow[4];
    req0 = 1; wr0 = 0; addr0 = 5'd3; last0 = 1;
    tick();
    req1 = 1; wr1 = 0; addr1 = 5'd4; last1 = 1;
    tick();
    req0 = 0;
    tick();
    req1 = 0;
    tick();
    check("t5_rvalid0", obs_rv0, 1'b1);
    check("t5_rdata0", obs_rdata, exp3);
    tick();
    check("t5_rvalid1", obs_rv1, 1'b1);
    check("t5_rdata1", obs_rdata, exp4);

    // Scenario 6: R1 writes DONE flag then polls it back.
    wr_cnt = 0;
    req1 = 1; wr1 = 1; addr1 = 5'd0; wdata1 = 256'd1; last1 = 0;
    tick(); wr_cnt += int'(obs_wr_en);
    tick(); wr_cnt += int'(obs_wr_en);
    wr1 = 0; last1 = 1;
    tick(); wr_cnt += int'(obs_wr_en);
    req1 = 0;
    tick(); wr_cnt += int'(obs_wr_en);
    tick(); wr_cnt += int'(obs_wr_en);
    check("t6_wr_en_cycles", wr_cnt, 1);
    check("t6_rvalid1", obs_rv1, 1'b1);
    check("t6_rdata_flag", obs_rdata[31:0], 32'd1);

    // Random traffic with a reset dropped in mid-stream.
    rem[0] = 0; rem[1] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (rem[i] == 0 && $urandom_range(0, 3) == 0) rem[i] = $urandom_range(1, 24);
        else if (rem[i] > 0 && $urandom_range(0, 49) == 0) rem[i] = 0;
      end
      rst    = (c >= 1500 && c < 1502);
      req0   = rem[0] > 0; last0 = rem[0] == 1;
      wr0    = 1'($urandom_range(0, 1)); addr0 = AW'($urandom); wdata0 = rand256();
      req1   = rem[1] > 0; last1 = rem[1] == 1;
      wr1    = 1'($urandom_range(0, 1)); addr1 = AW'($urandom); wdata1 = rand256();
      tick();
      if (m_gnt0) rem[0]--;
      if (m_gnt1) rem[1]--;
    end
    idle_inputs();
    rst = 0;
    for (int k = 0; k < 4; k++) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
